div_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the DIV/DIVU datapath behind the EX stage.
- Accepts one divide request, runs a 32-iteration restoring division and holds the pipeline stalled while it runs.
- Delivers {remainder, quotient} for the HI/LO write (HI = remainder, LO = quotient) with a one-cycle ready pulse.
- Replaces the single-cycle DIV ALU op; the ID-decoded signed flag selects DIV vs DIVU.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_seq_ctrl_if.sv | 32 +++
 rtl/div_seq_ctrl_step.sv | 35 +++
 rtl/div_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider slice.
//   DIV_WIDTH     default operand width
//   DIV_ITERS     restoring iterations per divide (one per operand bit)
//   HI_MSB/LO_MSB bit positions of the remainder (HI) and quotient (LO)
//                 fields inside result_o = {remainder, quotient}
//   div_state_t   sequencer state encoding
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;
  localparam int HI_MSB    = 2 * DIV_WIDTH - 1;
  localparam int LO_MSB    = DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: request/result bundle between the EX stage and the
// sequential divider.
//   master (EX stage): drives start_i, signed_i, dividend_i, divisor_i,
//                      cancel_i; receives stall_o, busy_o, ready_o, result_o
//   slave  (divider) : the mirror image
interface div_seq_ctrl_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic                 cancel_i;
  logic                 stall_o;
  logic                 busy_o;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i,
    input  stall_o, busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
    output stall_o, busy_o, ready_o, result_o
  );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// div_step: one combinational restoring-division iteration.
//   i_rem     partial remainder, WIDTH+1 bits
//   i_quo     dividend bits still to be consumed / quotient bits produced
//   i_divisor divisor magnitude
//   o_rem     next partial remainder
//   o_quo     next quotient/dividend register
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic             w_neg;
  logic             w_unused;

  // The remainder is always below the divisor between steps, so its top
  // bit is zero on entry; only WIDTH bits shift up, plus the next dividend bit.
  assign w_unused = i_rem[WIDTH];
  assign w_rem_sh = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  // One extra bit so the borrow shows up as the sign of the trial result.
  assign w_trial  = {1'b0, w_rem_sh} - {2'b00, i_divisor};
  assign w_neg    = w_trial[WIDTH+1];

  assign o_rem = w_neg ? w_rem_sh : w_trial[WIDTH:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU sequencer behind the EX stage.
// Runs a WIDTH-iteration restoring division on operand magnitudes, fixes
// up signs at the end and presents {remainder, quotient} with a one-cycle
// ready pulse while holding the pipeline stalled.
//   clk  rising-edge clock
//   rst  synchronous active-high reset, overrides everything
//   bus  div_seq_ctrl_if.slave: start/signed/dividend/divisor/cancel in,
//        stall/busy/ready/result out
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           rst,
  div_seq_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_step_rem;
  logic [WIDTH-1:0]   w_step_quo;
  logic [WIDTH-1:0]   w_quo_fin;
  logic [WIDTH-1:0]   w_rem_fin;

  assign w_accept = (r_state == IDLE) && bus.start_i && !bus.cancel_i;
  assign w_a_neg  = bus.signed_i && bus.dividend_i[WIDTH-1];
  assign w_b_neg  = bus.signed_i && bus.divisor_i[WIDTH-1];
  // Negating the most negative value wraps to itself, which is exactly its
  // unsigned magnitude.
  assign w_a_mag  = w_a_neg ? -bus.dividend_i : bus.dividend_i;
  assign w_b_mag  = w_b_neg ? -bus.divisor_i  : bus.divisor_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Sign fix-up applied to the final iteration's output so the result is
  // registered on the same edge the sequencer enters END.
  assign w_quo_fin = r_neg_q ? -w_step_quo : w_step_quo;
  assign w_rem_fin = r_neg_r ? -w_step_rem[WIDTH-1:0] : w_step_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_result <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (bus.divisor_i == '0) begin
              // Divide-by-zero result is staged in the working registers:
              // raw dividend as remainder, all-ones quotient.
              r_state <= DIVZERO;
              r_rem   <= {1'b0, bus.dividend_i};
              r_quo   <= '1;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_state <= ON;
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_dvsr  <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
        end
        ON: begin
          if (bus.cancel_i) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            if (r_cnt == LAST_CNT) begin
              r_state  <= END;
              r_cnt    <= '0;
              r_ready  <= 1'b1;
              r_result <= {w_rem_fin, w_quo_fin};
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DIVZERO: begin
          if (bus.cancel_i) begin
            r_state <= IDLE;
          end else begin
            r_state  <= END;
            r_ready  <= 1'b1;
            r_result <= {r_rem[WIDTH-1:0], r_quo};
          end
        end
        END: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so the requesting instruction is held in the
  // very cycle its start is accepted, and released the cycle cancel arrives.
  assign bus.stall_o  = w_accept ||
                        (!bus.cancel_i && ((r_state == ON) || (r_state == DIVZERO)));
  assign bus.busy_o   = (r_state != IDLE);
  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_ctrl_if #(.WIDTH(32)) bus ();

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ready = 0;
  int          cyc     = 0;
  int          last_ready_cyc = 0;
  int          prev_ready_cyc = 0;
  logic [63:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.ready_o) begin
      n_ready++;
      prev_ready_cyc = last_ready_cyc;
      last_ready_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", bus.result_o, 64'h0);
        n_fail += (bus.result_o == 64'h0) ? 1 : 0;
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("result", bus.result_o, e);
        $display("[TB] result HI=%h LO=%h expected HI=%h LO=%h",
                 bus.result_o[HI_MSB:LO_MSB+1], bus.result_o[LO_MSB:0],
                 e[HI_MSB:LO_MSB+1], e[LO_MSB:0]);
      end
    end
  end

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sq, sr;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = int'(a);
      sb = int'(b);
      sq = sa / sb;
      sr = sa % sb;
      return {32'(sr), 32'(sq)};
    end
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy_o) return;
      tick();
    end
    chk("idle_timeout", 64'(bus.busy_o), 64'h0);
  endtask

  task automatic wait_ready_from(input int r0, input int target);
    for (int i = 0; i < 80; i++) begin
      if (n_ready >= r0 + target) return;
      tick();
    end
    chk("ready_timeout", 64'(n_ready - r0), 64'(target));
  endtask

  task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start_i    = 1'b1;
    bus.signed_i   = s;
    bus.dividend_i = a;
    bus.divisor_i  = b;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e);
    int r0;
    wait_idle();
    r0 = n_ready;
    drive_start(s, a, b);
    sb_q.push_back(e);
    $display("[TB] start signed=%0b a=%h b=%h", s, a, b);
    tick();
    bus.start_i = 1'b0;
    wait_ready_from(r0, 1);
  endtask

  vec_t vecs[14];

  initial begin
    int c0, r0;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h2,        32'hE}};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000}};
    vecs[3]  = '{1'b0, 32'h1234,       32'h0,          {32'h1234,     32'hFFFF_FFFF}};
    vecs[4]  = '{1'b1, 32'h1234,       32'h0,          {32'h1234,     32'hFFFF_FFFF}};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'h0,          {32'hFFFF_FFF9, 32'hFFFF_FFFF}};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h1,          {32'h0,        32'hFFFF_FFFF}};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0,        32'h1}};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,         {32'h5,        32'h0}};
    vecs[9]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1,        32'hFFFF_FFFD}};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h3}};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0}};
    vecs[12] = '{1'b1, 32'h0,          32'd5,          {32'h0,        32'h0}};
    vecs[13] = '{1'b0, 32'd9,          32'd3,          {32'h0,        32'h3}};

    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.cancel_i   = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready",  64'(bus.ready_o),  64'h0);
    chk("rst_busy",   64'(bus.busy_o),   64'h0);
    chk("rst_stall",  64'(bus.stall_o),  64'h0);
    chk("rst_result", bus.result_o,      64'h0);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 14; i++)
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Pseudo-random vectors against the behavioural model
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(1, 0));
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : ((i < 4) ? 32'($urandom_range(1000, 1)) : $urandom);
      run_div(rs, ra, rb, model(rs, ra, rb));
    end

    // Latency and stall profile: DIVU 100/7
    wait_idle();
    c0 = cyc;
    drive_start(1'b0, 32'd100, 32'd7);
    sb_q.push_back({32'h2, 32'hE});
    #1;
    chk("lat_stall_T", 64'(bus.stall_o), 64'h1);
    tick();
    bus.start_i = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("lat_flags_T+%0d", k),
          64'({bus.stall_o, bus.ready_o, bus.busy_o}),
          64'({k <= 32, k == 33, k <= 33}));
      tick();
    end
    chk("lat_ready_cycle", 64'(last_ready_cyc), 64'(c0 + 33));

    // Divide by zero path: DIVU 0x1234/0
    wait_idle();
    c0 = cyc;
    drive_start(1'b0, 32'h1234, 32'h0);
    sb_q.push_back({32'h1234, 32'hFFFF_FFFF});
    #1;
    chk("dz_stall_T", 64'(bus.stall_o), 64'h1);
    tick();
    bus.start_i = 1'b0;
    chk("dz_T+1", 64'({bus.stall_o, bus.ready_o, bus.busy_o}), 64'(3'b101));
    tick();
    chk("dz_T+2", 64'({bus.stall_o, bus.ready_o, bus.busy_o}), 64'(3'b011));
    tick();
    chk("dz_T+3", 64'({bus.stall_o, bus.ready_o, bus.busy_o}), 64'(3'b000));
    chk("dz_ready_cycle", 64'(last_ready_cyc), 64'(c0 + 2));

    // Cancel at counter=10, then a fresh DIVU 9/3 two cycles later
    wait_idle();
    r0 = n_ready;
    drive_start(1'b0, 32'd1000, 32'd3);
    tick();
    bus.start_i = 1'b0;
    repeat (10) tick();
    bus.cancel_i = 1'b1;
    #1;
    chk("cancel_stall", 64'(bus.stall_o), 64'h0);
    tick();
    bus.cancel_i = 1'b0;
    chk("cancel_idle", 64'({bus.busy_o, bus.ready_o}), 64'h0);
    tick(); tick();
    c0 = cyc;
    drive_start(1'b0, 32'd9, 32'd3);
    sb_q.push_back({32'h0, 32'h3});
    tick();
    bus.start_i = 1'b0;
    wait_ready_from(r0, 1);
    chk("cancel_next_ready_cycle", 64'(last_ready_cyc), 64'(c0 + 33));
    tick(); tick();
    chk("cancel_ready_count", 64'(n_ready - r0), 64'h1);

    // Reset at counter=20 kills the divide
    wait_idle();
    r0 = n_ready;
    drive_start(1'b1, 32'hFFFF_0000, 32'd13);
    tick();
    bus.start_i = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outputs",
        {61'h0, bus.stall_o, bus.busy_o, bus.ready_o} | bus.result_o, 64'h0);
    repeat (40) tick();
    chk("midrst_no_ready", 64'(n_ready - r0), 64'h0);

    // start pulses and operand changes during ON are ignored
    wait_idle();
    r0 = n_ready;
    drive_start(1'b0, 32'd50000, 32'd7);
    sb_q.push_back({32'd6, 32'd7142});
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 6; k++) begin
      drive_start(1'(k), 32'd1, 32'd1);
      tick();
    end
    bus.start_i = 1'b0;
    repeat (40) tick();
    chk("ignore_one_ready", 64'(n_ready - r0), 64'h1);

    // Back-to-back: start held through END
    wait_idle();
    r0 = n_ready;
    drive_start(1'b0, 32'd100, 32'd7);
    sb_q.push_back({32'h2, 32'hE});
    sb_q.push_back({32'h2, 32'hE});
    wait_ready_from(r0, 1);
    tick();
    tick();
    bus.start_i = 1'b0;
    wait_ready_from(r0, 2);
    chk("b2b_spacing", 64'(last_ready_cyc - prev_ready_cyc), 64'd34);
    repeat (40) tick();
    chk("b2b_ready_count", 64'(n_ready - r0), 64'h2);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
